ram_block_copier: RTL and testbench
===================================

Name: ram_block_copier

Overview:
- Initiator for the dual-port RAM access protocol: per-port address, byte write-enable mask, write data and read enable; read data and read ack returned exactly one cycle after the read enable.
- Copies a block of LEN words from a source base address to a destination base address in the same dual-port RAM.
- Reads on the RAM's port A and writes on port B, sustaining one word per cycle.
- Sits between a control/CSR master and the accelerator's local dual-port RAM.

Parameters:
- DATA_WIDTH, 32, word width; must match the attached RAM.
- RAM_DEPTH, 512, words in the RAM; ADDR_WIDTH = $clog2(RAM_DEPTH) (localparam).
- WREN_WIDTH (localparam), (DATA_WIDTH+7)/8, byte-lane write-enable width.
- LEN_WIDTH (localparam), ADDR_WIDTH+1, so a full-depth copy is expressible.

Ports:
- clkIn  input  1  clock; all logic on rising edge.
- rstIn  input  1  asynchronous, active-low reset.
- startIn  input  1  single-cycle command strobe; sampled only in IDLE.
- srcAddrIn  input  ADDR_WIDTH  source base; captured on accepted start.
- dstAddrIn  input  ADDR_WIDTH  destination base; captured on accepted start.
- lenIn  input  LEN_WIDTH  word count, 0..RAM_DEPTH; captured on accepted start.
- busyOut  output  1  high from the cycle after an accepted start until DONE is entered.
- doneOut  output  1  one-cycle completion pulse.
- rdAddrOut  output  ADDR_WIDTH  to RAM port A address.
- rdEnOut  output  1  to RAM port A read enable.
- rdDataIn  input  DATA_WIDTH  from RAM port A read data.
- rdAckIn  input  1  from RAM port A read ack.
- wrAddrOut  output  ADDR_WIDTH  to RAM port B address.
- wrEnOut  output  WREN_WIDTH  to RAM port B byte enables; all-ones or all-zeros.
- wrDataOut  output  DATA_WIDTH  to RAM port B write data.

Behaviour:
- Reset (async, rstIn=0): FSM to IDLE. All outputs 0: busyOut, doneOut, rdEnOut, rdAddrOut, wrEnOut, wrAddrOut, wrDataOut. Read/write counters cleared. Reset mid-copy aborts immediately; no further RAM accesses; partial destination contents remain.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On startIn=1 with lenIn!=0: capture inputs, go to READ.
  - On startIn=1 with lenIn==0: go directly to DONE; no RAM access.
- READ:
  - Each cycle drive rdEnOut=1 and rdAddrOut=(src+k) mod RAM_DEPTH, for k=0..len-1. These are registered outputs, so the first read is visible the cycle after start.
  - After issuing read len-1, go to DRAIN.
- Write path (independent of state):
  - Every cycle rdAckIn=1 while busy, register a write: wrEnOut=all-ones, wrDataOut=rdDataIn, wrAddrOut=(dst+j) mod RAM_DEPTH, with j incrementing per ack.
  - Write appears one cycle after the ack, i.e. two cycles after its read enable.
  - Otherwise wrEnOut=0.
- DRAIN: wait until write count equals len (last write driven), then go to DONE.
- DONE: doneOut=1 for exactly one cycle, busyOut=0, return to IDLE.
- Latency: for len=N, doneOut is asserted N+3 cycles after the start cycle. Start cycle = cycle 0; reads cycles 1..N; writes cycles 3..N+2; done cycle N+3.
- Address arithmetic: ADDR_WIDTH-bit unsigned add; wrap-around is required behaviour (src=RAM_DEPTH-1 continues at 0).
- startIn outside IDLE is ignored; no queueing.
- rdAckIn while not busy is ignored; produces no write.
- Overlapping source/destination ranges are unsupported; resulting contents are undefined. The bench must not check them.
- len=RAM_DEPTH copies the whole RAM; the counters must not overflow.

Optional Feature:
- Macro RAM_COPY_CHECKSUM_EN.
- When defined:
  - Extra output checksumOut (DATA_WIDTH): running XOR of every word written.
  - Cleared to 0 on accepted start and on reset.
  - Final value stable from the doneOut cycle until the next accepted start.
- When undefined: port and logic absent; the rest of the behaviour is identical.

Test Plan:
- Reset then idle, 20 cycles -> all outputs 0, no rdEnOut/wrEnOut activity.
- RAM[0..3]={11,22,33,44}; start src=0, dst=100, len=4 -> reads cycles 1-4 at 0..3; writes cycles 3-6 at 100..103 with 11,22,33,44; doneOut cycle 7 only; RAM[100..103] matches.
- start src=510, dst=20, len=4 (RAM_DEPTH=512) -> rdAddrOut 510,511,0,1; wrAddrOut 20..23; data preserved.
- start len=0 -> no rdEnOut/wrEnOut; doneOut one cycle after start; busyOut stays 0.
- start len=8, pulse startIn again at cycle 3 with dst=300 -> second start ignored; exactly 8 writes to original dst; single doneOut.
- start len=16, drive rstIn=0 at cycle 6 -> outputs 0 asynchronously; no writes after reset; next start after release runs normally. With RAM_COPY_CHECKSUM_EN, a full 4-word copy of {1,2,4,8} -> checksumOut=15.

Source files
------------

// File: rtl/ram_block_copier.sv
// Block copier for a dual-port RAM: streams LEN words from port A reads to port B writes.
// Optional RAM_COPY_CHECKSUM_EN adds checksumOut, a running XOR of every word written.
module ram_block_copier #(
    parameter  int DATA_WIDTH = 32,
    parameter  int RAM_DEPTH  = 512,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH),
    localparam int WREN_WIDTH = (DATA_WIDTH + 7) / 8,
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  startIn,
    input  logic [ADDR_WIDTH-1:0] srcAddrIn,
    input  logic [ADDR_WIDTH-1:0] dstAddrIn,
    input  logic [LEN_WIDTH-1:0]  lenIn,
    output logic                  busyOut,
    output logic                  doneOut,
    output logic [ADDR_WIDTH-1:0] rdAddrOut,
    output logic                  rdEnOut,
    input  logic [DATA_WIDTH-1:0] rdDataIn,
    input  logic                  rdAckIn,
    output logic [ADDR_WIDTH-1:0] wrAddrOut,
    output logic [WREN_WIDTH-1:0] wrEnOut,
`ifdef RAM_COPY_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksumOut,
`endif
    output logic [DATA_WIDTH-1:0] wrDataOut
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state;
    state_t                stateNext;
    logic [ADDR_WIDTH-1:0] srcAddr;
    logic [ADDR_WIDTH-1:0] dstAddr;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  rdCnt;
    logic [LEN_WIDTH-1:0]  wrCnt;
    logic                  startAccept;

    assign startAccept = (state == IDLE) && startIn;

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // rdCnt counts reads already issued, so READ ends once it reaches len
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startIn) stateNext = (lenIn == '0) ? DONE : READ;
            READ:    if (rdCnt == len) stateNext = DRAIN;
            DRAIN:   if (wrCnt == len) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ---- read issue stage ----
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            srcAddr   <= '0;
            dstAddr   <= '0;
            len       <= '0;
            rdCnt     <= '0;
            rdEnOut   <= 1'b0;
            rdAddrOut <= '0;
            busyOut   <= 1'b0;
            doneOut   <= 1'b0;
        end else begin
            rdEnOut <= 1'b0;
            busyOut <= (stateNext == READ) || (stateNext == DRAIN);
            doneOut <= (stateNext == DONE);
            if (startAccept && (lenIn != '0)) begin
                srcAddr   <= srcAddrIn;
                dstAddr   <= dstAddrIn;
                len       <= lenIn;
                rdEnOut   <= 1'b1;
                rdAddrOut <= srcAddrIn;
                rdCnt     <= LEN_WIDTH'(1);
            end else if ((state == READ) && (rdCnt != len)) begin
                rdEnOut   <= 1'b1;
                rdAddrOut <= srcAddr + rdCnt[ADDR_WIDTH-1:0];
                rdCnt     <= rdCnt + LEN_WIDTH'(1);
            end
        end
    end

    // ---- write stage: one write per ack, independent of FSM state ----
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            wrCnt     <= '0;
            wrEnOut   <= '0;
            wrAddrOut <= '0;
            wrDataOut <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
            checksumOut <= '0;
`endif
        end else begin
            wrEnOut <= '0;
            if (startAccept) begin
                wrCnt <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
                checksumOut <= '0;
`endif
            end else if (rdAckIn && busyOut) begin
                wrEnOut   <= '1;
                wrDataOut <= rdDataIn;
                wrAddrOut <= dstAddr + wrCnt[ADDR_WIDTH-1:0];
                wrCnt     <= wrCnt + LEN_WIDTH'(1);
`ifdef RAM_COPY_CHECKSUM_EN
                checksumOut <= checksumOut ^ rdDataIn;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ram_block_copier.sv
// Scoreboard bench for ram_block_copier: a behavioural dual-port RAM plus queues of expected reads/writes.
module tb_ram_block_copier;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int LW    = 10;

    logic          clkIn = 1'b0;
    logic          rstIn;
    logic          startIn;
    logic [AW-1:0] srcAddrIn;
    logic [AW-1:0] dstAddrIn;
    logic [LW-1:0] lenIn;
    logic          busyOut;
    logic          doneOut;
    logic [AW-1:0] rdAddrOut;
    logic          rdEnOut;
    logic [DW-1:0] rdDataIn = '0;
    logic          rdAckIn = 1'b0;
    logic [AW-1:0] wrAddrOut;
    logic [3:0]    wrEnOut;
    logic [DW-1:0] wrDataOut;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksumOut;
`endif

    ram_block_copier #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn),
        .srcAddrIn(srcAddrIn), .dstAddrIn(dstAddrIn), .lenIn(lenIn),
        .busyOut(busyOut), .doneOut(doneOut),
        .rdAddrOut(rdAddrOut), .rdEnOut(rdEnOut), .rdDataIn(rdDataIn), .rdAckIn(rdAckIn),
        .wrAddrOut(wrAddrOut), .wrEnOut(wrEnOut),
`ifdef RAM_COPY_CHECKSUM_EN
        .checksumOut(checksumOut),
`endif
        .wrDataOut(wrDataOut)
    );

    always #5 clkIn = ~clkIn;

    int cyc = 0;
    always @(posedge clkIn) cyc <= cyc + 1;

    int vecCnt = 0;
    int errCnt = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] patt(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0101);
    endfunction

    // Behavioural dual-port RAM: port A read with one-cycle ack, port B byte-masked write
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          fillReq;
    logic          loadEn;
    int            loadAddr;
    logic [DW-1:0] loadData;

    always @(posedge clkIn) begin
        rdAckIn <= rdEnOut;
        if (rdEnOut) rdDataIn <= mem[rdAddrOut];
        if (fillReq) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= patt(i);
        end else if (loadEn) begin
            mem[loadAddr] <= loadData;
        end
        for (int b = 0; b < 4; b++)
            if (wrEnOut[b]) mem[wrAddrOut][8*b +: 8] <= wrDataOut[8*b +: 8];
    end

    typedef struct { int addr; int cyc; } rdExp_t;
    typedef struct { int addr; logic [DW-1:0] data; int cyc; } wrExp_t;
    rdExp_t rdQ[$];
    wrExp_t wrQ[$];
    rdExp_t re;
    wrExp_t we;
    int rdEvents = 0;
    int wrEvents = 0;
    int doneCnt  = 0;

    always @(negedge clkIn) begin
        if (rdEnOut) begin
            rdEvents++;
            if (rdQ.size() == 0) checkVal("rd_unexpected", 64'(rdEnOut), 0);
            else begin
                re = rdQ.pop_front();
                checkVal("rd_addr", 64'(rdAddrOut), 64'(re.addr));
                checkVal("rd_cyc", 64'(cyc), 64'(re.cyc));
            end
        end
        if (wrEnOut != 4'h0) begin
            wrEvents++;
            checkVal("wr_mask", 64'(wrEnOut), 64'hF);
            if (wrQ.size() == 0) checkVal("wr_unexpected", 64'(wrEnOut), 0);
            else begin
                we = wrQ.pop_front();
                checkVal("wr_addr", 64'(wrAddrOut), 64'(we.addr));
                checkVal("wr_data", 64'(wrDataOut), 64'(we.data));
                checkVal("wr_cyc", 64'(cyc), 64'(we.cyc));
            end
        end
        if (doneOut) doneCnt++;
    end

    task automatic poke(input int a, input logic [DW-1:0] d);
        @(posedge clkIn); #1;
        loadEn = 1'b1; loadAddr = a; loadData = d;
        @(posedge clkIn); #1;
        loadEn = 1'b0;
    endtask

    // Drive a one-cycle start and push the first nRd reads / nWr writes it should produce
    task automatic issueStart(input int src, input int dst, input int len,
                              input int nRd, input int nWr, output int c0);
        rdExp_t r;
        wrExp_t w;
        @(posedge clkIn); #1;
        startIn = 1'b1; srcAddrIn = AW'(src); dstAddrIn = AW'(dst); lenIn = LW'(len);
        c0 = cyc;
        for (int k = 0; k < nRd; k++) begin
            r.addr = (src + k) % DEPTH; r.cyc = c0 + 1 + k;
            rdQ.push_back(r);
        end
        for (int k = 0; k < nWr; k++) begin
            w.addr = (dst + k) % DEPTH; w.data = mem[(src + k) % DEPTH]; w.cyc = c0 + 3 + k;
            wrQ.push_back(w);
        end
        @(posedge clkIn); #1;
        startIn = 1'b0;
    endtask

    task automatic waitDone(input int c0, input int len, input int reAt, input int reDst);
        int expDone;
        bit found;
        expDone = (len == 0) ? c0 + 1 : c0 + len + 3;
        found = 0;
        for (int i = 0; i < len + 20 && !found; i++) begin
            @(negedge clkIn);
            if (reAt != 0 && cyc == c0 + reAt) begin
                startIn = 1'b1; dstAddrIn = AW'(reDst);
            end else begin
                startIn = 1'b0;
            end
            if (doneOut) begin
                found = 1;
                checkVal("done_cyc", 64'(cyc), 64'(expDone));
                checkVal("busy_at_done", 64'(busyOut), 0);
            end else begin
                checkVal("busy_run", 64'(busyOut), 64'(len != 0 && cyc > c0));
            end
        end
        startIn = 1'b0;
        checkVal("done_seen", 64'(found), 1);
        @(negedge clkIn);
        checkVal("done_pulse", 64'(doneOut), 0);
        checkVal("rd_q_left", 64'(rdQ.size()), 0);
        checkVal("wr_q_left", 64'(wrQ.size()), 0);
    endtask

    task automatic doCopy(input int src, input int dst, input int len,
                          input int reAt, input int reDst);
        int c0;
        issueStart(src, dst, len, len, len, c0);
        waitDone(c0, len, reAt, reDst);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecCnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, w0, d0;
        rstIn = 1'b0; startIn = 1'b0; srcAddrIn = '0; dstAddrIn = '0; lenIn = '0;
        loadEn = 1'b0; loadAddr = 0; loadData = '0; fillReq = 1'b1;
        #3;
        checkVal("rst_busy", 64'(busyOut), 0);
        checkVal("rst_done", 64'(doneOut), 0);
        checkVal("rst_rden", 64'(rdEnOut), 0);
        checkVal("rst_rdaddr", 64'(rdAddrOut), 0);
        checkVal("rst_wren", 64'(wrEnOut), 0);
        checkVal("rst_wraddr", 64'(wrAddrOut), 0);
        checkVal("rst_wrdata", 64'(wrDataOut), 0);
        repeat (2) @(posedge clkIn);
        #1 fillReq = 1'b0;
        @(negedge clkIn);
        rstIn = 1'b1;

        r0 = rdEvents; w0 = wrEvents;
        repeat (20) @(negedge clkIn);
        checkVal("idle_rd", 64'(rdEvents - r0), 0);
        checkVal("idle_wr", 64'(wrEvents - w0), 0);
        checkVal("idle_busy", 64'(busyOut), 0);
        checkVal("idle_done", 64'(doneCnt), 0);

        // Basic 4-word copy
        poke(0, 32'd11); poke(1, 32'd22); poke(2, 32'd33); poke(3, 32'd44);
        d0 = doneCnt;
        doCopy(0, 100, 4, 0, 0);
        checkVal("basic_done_cnt", 64'(doneCnt - d0), 1);
        checkVal("ram100", 64'(mem[100]), 11);
        checkVal("ram101", 64'(mem[101]), 22);
        checkVal("ram102", 64'(mem[102]), 33);
        checkVal("ram103", 64'(mem[103]), 44);

        // Source address wraps past the top of the RAM
        doCopy(510, 20, 4, 0, 0);
        checkVal("wrap20", 64'(mem[20]), 64'(patt(510)));
        checkVal("wrap21", 64'(mem[21]), 64'(patt(511)));
        checkVal("wrap22", 64'(mem[22]), 11);
        checkVal("wrap23", 64'(mem[23]), 22);

        // Zero length: straight to DONE, no RAM traffic
        r0 = rdEvents; w0 = wrEvents;
        doCopy(5, 6, 0, 0, 0);
        checkVal("len0_rd", 64'(rdEvents - r0), 0);
        checkVal("len0_wr", 64'(wrEvents - w0), 0);

        // Restart during a copy is ignored
        d0 = doneCnt; w0 = wrEvents;
        doCopy(50, 200, 8, 3, 300);
        repeat (4) @(negedge clkIn);
        checkVal("restart_done_cnt", 64'(doneCnt - d0), 1);
        checkVal("restart_wr_cnt", 64'(wrEvents - w0), 8);
        checkVal("restart_ram300", 64'(mem[300]), 64'(patt(300)));
        checkVal("restart_ram207", 64'(mem[207]), 64'(patt(57)));

        // Asynchronous reset in the middle of a 16-word copy
        d0 = doneCnt;
        issueStart(40, 150, 16, 5, 3, c0);
        repeat (5) @(posedge clkIn);
        #2 rstIn = 1'b0;
        #1;
        checkVal("abort_busy", 64'(busyOut), 0);
        checkVal("abort_rden", 64'(rdEnOut), 0);
        checkVal("abort_rdaddr", 64'(rdAddrOut), 0);
        checkVal("abort_wren", 64'(wrEnOut), 0);
        checkVal("abort_wraddr", 64'(wrAddrOut), 0);
        checkVal("abort_wrdata", 64'(wrDataOut), 0);
        repeat (3) @(negedge clkIn);
        @(posedge clkIn);
        #3 rstIn = 1'b1;
        w0 = wrEvents;
        repeat (10) @(negedge clkIn);
        checkVal("abort_no_wr", 64'(wrEvents - w0), 0);
        checkVal("abort_no_done", 64'(doneCnt - d0), 0);
        checkVal("abort_rd_q", 64'(rdQ.size()), 0);
        checkVal("abort_wr_q", 64'(wrQ.size()), 0);
        checkVal("abort_ram153", 64'(mem[153]), 64'(patt(153)));
        doCopy(60, 400, 5, 0, 0);
        checkVal("post_abort_ram400", 64'(mem[400]), 64'(patt(60)));
        checkVal("post_abort_ram404", 64'(mem[404]), 64'(patt(64)));

`ifdef RAM_COPY_CHECKSUM_EN
        poke(250, 32'd1); poke(251, 32'd2); poke(252, 32'd4); poke(253, 32'd8);
        doCopy(250, 260, 4, 0, 0);
        checkVal("checksum", 64'(checksumOut), 15);
        repeat (3) @(negedge clkIn);
        checkVal("checksum_hold", 64'(checksumOut), 15);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
